// File: rtl/ex_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ex_muldiv_ctrl
// Iterative multiply/divide unit for the EX stage. It owns the HI and LO
// registers and produces the pipeline stall for dependent instructions.
// MULT/MULTU use a radix-2 shift-add loop. DIV/DIVU use a radix-2 restoring
// shift-subtract loop on operand magnitudes, with the signs fixed up at the end.
//
// Ports
//   Clk              rising-edge clock
//   Reset_L          synchronous active-low reset
//   MulDiv_Start_EX  EX holds MULT/MULTU/DIV/DIVU
//   MulDiv_Op_EX     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   ALU_Data_1_EX    rs operand (multiplicand / dividend)
//   Read_Data_2_EX   rt operand (multiplier / divisor)
//   HI_LO_Read_EX    EX holds MFHI/MFLO
//   Flush_EX         abort the in-flight operation
//   MulDiv_Busy      operation in progress (CALC or FIX)
//   Stall_EX         hold IF/ID/EX while a dependent instruction waits
//   HI_Out, LO_Out   HI and LO registers
//   Div_By_Zero      last accepted divide had rt = 0
// ---------------------------------------------------------------------------
module ex_muldiv_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset_L,
    input  logic                  MulDiv_Start_EX,
    input  logic [1:0]            MulDiv_Op_EX,
    input  logic [DATA_WIDTH-1:0] ALU_Data_1_EX,
    input  logic [DATA_WIDTH-1:0] Read_Data_2_EX,
    input  logic                  HI_LO_Read_EX,
    input  logic                  Flush_EX,
    output logic                  MulDiv_Busy,
    output logic                  Stall_EX,
    output logic [DATA_WIDTH-1:0] HI_Out,
    output logic [DATA_WIDTH-1:0] LO_Out,
    output logic                  Div_By_Zero
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state_q;
    logic [4:0]     count_q;
    logic [1:0]     op_q;
    logic           signA_q;
    logic           signB_q;
    logic [W-1:0]   keep_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic           divZero_q;

    logic           signedIn;
    logic [W-1:0]   magA;
    logic [W-1:0]   magB;
    logic [W:0]     mulSum;
    logic [W:0]     divShift;
    logic [W-1:0]   divDiff;
    logic           divGe;
    logic [2*W-1:0] acc_d;
    logic [2*W-1:0] product;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;

    // Operand magnitudes for the signed ops. The most negative value maps
    // to itself, which is the correct unsigned magnitude.
    always_comb begin
        signedIn = ~MulDiv_Op_EX[0];
        magA     = ALU_Data_1_EX;
        magB     = Read_Data_2_EX;
        if (signedIn && ALU_Data_1_EX[W-1]) magA = -ALU_Data_1_EX;
        if (signedIn && Read_Data_2_EX[W-1]) magB = -Read_Data_2_EX;
    end

    // One iteration step. The accumulator holds {partial product, multiplier}
    // for multiply and {remainder, dividend/quotient} for divide. keep_q
    // holds the multiplicand or the divisor.
    always_comb begin
        mulSum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, keep_q} : '0);
        divShift = {acc_q[2*W-1:W], acc_q[W-1]};
        divGe    = divShift >= {1'b0, keep_q};
        divDiff  = divShift[W-1:0] - keep_q;
        if (op_q[1]) begin
            if (divGe) acc_d = {divDiff, acc_q[W-2:0], 1'b1};
            else       acc_d = {divShift[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            acc_d = {mulSum, acc_q[W-1:1]};
        end
    end

    // Sign fix-up applied when leaving FIX. Only DIV and MULT are signed.
    // The remainder takes the sign of the dividend.
    always_comb begin
        product = acc_q;
        quot    = acc_q[W-1:0];
        rem     = acc_q[2*W-1:W];
        if (op_q == 2'b00 && (signA_q ^ signB_q)) product = -acc_q;
        if (op_q == 2'b10 && (signA_q ^ signB_q)) quot = -acc_q[W-1:0];
        if (op_q == 2'b10 && signA_q) rem = -acc_q[2*W-1:W];
    end

    // Control FSM plus datapath registers. A start is sampled only in IDLE.
    // A flush in CALC or FIX drops the work without touching HI/LO.
    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= '0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            keep_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            divZero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MulDiv_Start_EX && !Flush_EX) begin
                        if (MulDiv_Op_EX[1] && Read_Data_2_EX == '0) begin
                            divZero_q <= 1'b1;
                        end else begin
                            op_q      <= MulDiv_Op_EX;
                            signA_q   <= signedIn & ALU_Data_1_EX[W-1];
                            signB_q   <= signedIn & Read_Data_2_EX[W-1];
                            keep_q    <= MulDiv_Op_EX[1] ? magB : magA;
                            acc_q     <= {{W{1'b0}}, (MulDiv_Op_EX[1] ? magA : magB)};
                            count_q   <= '0;
                            divZero_q <= 1'b0;
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (Flush_EX) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q   <= acc_d;
                        count_q <= count_q + 5'd1;
                        if (count_q == 5'd31) state_q <= FIX;
                    end
                end
                FIX: begin
                    if (!Flush_EX) begin
                        if (op_q[1]) begin
                            hi_q <= rem;
                            lo_q <= quot;
                        end else begin
                            hi_q <= product[2*W-1:W];
                            lo_q <= product[W-1:0];
                        end
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MulDiv_Busy = (state_q != IDLE);
    assign Stall_EX    = MulDiv_Busy & (MulDiv_Start_EX | HI_LO_Read_EX);
    assign HI_Out      = hi_q;
    assign LO_Out      = lo_q;
    assign Div_By_Zero = divZero_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_ctrl
// Directed bench for ex_muldiv_ctrl. Inputs change 1 ns after a rising edge.
// Outputs are checked in the same window, away from the clock edge.
// modelHi/modelLo hold the hand-computed HI/LO values the DUT should hold.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_L;
    logic        MulDiv_Start_EX;
    logic [1:0]  MulDiv_Op_EX;
    logic [31:0] ALU_Data_1_EX;
    logic [31:0] Read_Data_2_EX;
    logic        HI_LO_Read_EX;
    logic        Flush_EX;
    logic        MulDiv_Busy;
    logic        Stall_EX;
    logic [31:0] HI_Out;
    logic [31:0] LO_Out;
    logic        Div_By_Zero;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] modelHi     = '0;
    logic [31:0] modelLo     = '0;

    ex_muldiv_ctrl #(.DATA_WIDTH(32)) dut (
        .Clk             (Clk),
        .Reset_L         (Reset_L),
        .MulDiv_Start_EX (MulDiv_Start_EX),
        .MulDiv_Op_EX    (MulDiv_Op_EX),
        .ALU_Data_1_EX   (ALU_Data_1_EX),
        .Read_Data_2_EX  (Read_Data_2_EX),
        .HI_LO_Read_EX   (HI_LO_Read_EX),
        .Flush_EX        (Flush_EX),
        .MulDiv_Busy     (MulDiv_Busy),
        .Stall_EX        (Stall_EX),
        .HI_Out          (HI_Out),
        .LO_Out          (LO_Out),
        .Div_By_Zero     (Div_By_Zero)
    );

    always #5 Clk = ~Clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic hilo, input logic flush);
        MulDiv_Start_EX = start;
        MulDiv_Op_EX    = op;
        ALU_Data_1_EX   = a;
        Read_Data_2_EX  = b;
        HI_LO_Read_EX   = hilo;
        Flush_EX        = flush;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Tick n times and count the cycles in which Busy was high.
    task automatic waitCycles(input int n, output int busyCnt);
        busyCnt = 0;
        repeat (n) begin
            if (MulDiv_Busy) busyCnt++;
            tick();
        end
    endtask

    // Full operation: the start is accepted in the current cycle N. HI/LO must
    // still hold the old values in cycle N+33 and the new ones in N+34.
    task automatic doOp(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expHi, input logic [31:0] expLo);
        int bc;
        applyStimulus(1'b1, op, a, b, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        waitCycles(32, bc);
        checkOutput({tag, "_busyCalc"}, 64'(bc), 64'd32);
        checkOutput({tag, "_busyFix"}, 64'(MulDiv_Busy), 64'd1);
        checkOutput({tag, "_hiloHeld"}, {HI_Out, LO_Out}, {modelHi, modelLo});
        tick();
        modelHi = expHi;
        modelLo = expLo;
        checkOutput({tag, "_busyDone"}, 64'(MulDiv_Busy), 64'd0);
        checkOutput({tag, "_hilo"}, {HI_Out, LO_Out}, {expHi, expLo});
        checkOutput({tag, "_dbz"}, 64'(Div_By_Zero), 64'd0);
    endtask

    initial begin
        int cnt;
        Reset_L = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_busy", 64'(MulDiv_Busy), 64'd0);
        checkOutput("reset_stall", 64'(Stall_EX), 64'd0);
        checkOutput("reset_hilo", {HI_Out, LO_Out}, 64'd0);
        checkOutput("reset_dbz", 64'(Div_By_Zero), 64'd0);
        Reset_L = 1'b1;
        tick();

        // Main function across signed and unsigned multiply and divide.
        doOp("mult",     2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        doOp("divu",     2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
        doOp("divNeg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        doOp("divWrap",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        doOp("multuMax", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        doOp("divNegB",  2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        doOp("divuBig",  2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);

        // A divide by zero flags the error, never goes busy and keeps HI/LO.
        applyStimulus(1'b1, 2'b10, 32'd55, 32'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("dbz_flag", 64'(Div_By_Zero), 64'd1);
        checkOutput("dbz_busy", 64'(MulDiv_Busy), 64'd0);
        tick();
        checkOutput("dbz_busyLater", 64'(MulDiv_Busy), 64'd0);
        checkOutput("dbz_hilo", {HI_Out, LO_Out}, {modelHi, modelLo});

        // The next accepted op clears the flag. doOp also checks it ends at 0.
        doOp("multPos", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42);

        // MFHI two cycles after the start stalls until Busy drops. An
        // unrelated instruction in the window does not stall.
        applyStimulus(1'b1, 2'b00, 32'd5, 32'hFFFFFFFD, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        HI_LO_Read_EX = 1'b1;
        #1;
        checkOutput("mfhi_stallOn", 64'(Stall_EX), 64'd1);
        tick();
        HI_LO_Read_EX = 1'b0;
        #1;
        checkOutput("indep_noStall", 64'(Stall_EX), 64'd0);
        HI_LO_Read_EX = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 40 && MulDiv_Busy; i++) begin
            if (Stall_EX) cnt++;
            tick();
        end
        checkOutput("mfhi_stallCycles", 64'(cnt), 64'd30);
        checkOutput("mfhi_stallOff", 64'(Stall_EX), 64'd0);
        modelHi = 32'hFFFFFFFF;
        modelLo = 32'hFFFFFFF1;
        checkOutput("mfhi_hilo", {HI_Out, LO_Out}, {modelHi, modelLo});
        HI_LO_Read_EX = 1'b0;

        // A flush at CALC counter 10 returns to IDLE with HI/LO untouched.
        applyStimulus(1'b1, 2'b01, 32'd9, 32'd9, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (10) tick();
        Flush_EX = 1'b1;
        tick();
        Flush_EX = 1'b0;
        checkOutput("flush_busy", 64'(MulDiv_Busy), 64'd0);
        repeat (30) tick();
        checkOutput("flush_hilo", {HI_Out, LO_Out}, {modelHi, modelLo});

        // A flush together with a start in IDLE blocks acceptance.
        applyStimulus(1'b1, 2'b01, 32'd3, 32'd3, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("flushStart_busy", 64'(MulDiv_Busy), 64'd0);

        // Reset in the middle of CALC wins over a start that is still held.
        applyStimulus(1'b1, 2'b01, 32'd11, 32'd13, 1'b0, 1'b0);
        tick();
        repeat (5) tick();
        Reset_L = 1'b0;
        tick();
        checkOutput("midReset_busy", 64'(MulDiv_Busy), 64'd0);
        checkOutput("midReset_stall", 64'(Stall_EX), 64'd0);
        checkOutput("midReset_hilo", {HI_Out, LO_Out}, 64'd0);
        checkOutput("midReset_dbz", 64'(Div_By_Zero), 64'd0);
        Reset_L = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        modelHi = '0;
        modelLo = '0;
        tick();

        // Back-to-back MULTU: the second start is held with a stall and
        // accepted in the cycle Busy falls.
        applyStimulus(1'b1, 2'b01, 32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b01, 32'h00010000, 32'h00010000, 1'b0, 1'b0);
        #1;
        checkOutput("b2b_stall", 64'(Stall_EX), 64'd1);
        for (int i = 0; i < 40 && MulDiv_Busy; i++) tick();
        checkOutput("b2b_firstResult", {HI_Out, LO_Out}, 64'd12);
        checkOutput("b2b_stallFree", 64'(Stall_EX), 64'd0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("b2b_secondBusy", 64'(MulDiv_Busy), 64'd1);
        waitCycles(33, cnt);
        checkOutput("b2b_secondBusyCycles", 64'(cnt), 64'd33);
        checkOutput("b2b_secondResult", {HI_Out, LO_Out}, 64'h00000001_00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have port Clk  input  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port Reset_L  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port MulDiv_Start_EX  input  1  EX holds a MULT/MULTU/DIV/DIVU instruction.
REQ-005 The block SHALL have port MulDiv_Op_EX  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port ALU_Data_1_EX  input  32  rs operand (multiplicand/dividend).
REQ-007 The block SHALL have port Read_Data_2_EX  input  32  rt operand (multiplier/divisor), taken before the ALUSrc mux.
REQ-008 The block SHALL have port HI_LO_Read_EX  input  1  EX holds MFHI/MFLO.
REQ-009 The block SHALL have port Flush_EX  input  1  abort the in-flight operation.
REQ-010 The block SHALL have port MulDiv_Busy  output  1  an operation is in progress.
REQ-011 The block SHALL have port Stall_EX  output  1  hold IF/ID/EX and bubble MEM.
REQ-012 The block SHALL have port HI_Out  output  32  HI register.
REQ-013 The block SHALL have port LO_Out  output  32  LO register.
REQ-014 The block SHALL have port Div_By_Zero  output  1  last accepted divide had rt = 0.

Function
REQ-015 FSM states SHALL be IDLE, CALC, FIX; IDLE is the reset state.
REQ-016 IDLE: MulDiv_Start_EX=1 and Flush_EX=0 -> latch operand magnitudes (signed ops) or raw values (unsigned ops), latch op and operand signs, counter=0, clear Div_By_Zero, go to CALC.
REQ-017 IDLE, divide with Read_Data_2_EX=0: SHALL set Div_By_Zero=1, stay in IDLE, leave HI/LO unchanged.
REQ-018 CALC SHALL perform one radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide; counter 0..31, then go to FIX.
REQ-019 FIX, multiply: {HI,LO} SHALL get the 64-bit product, two's-complement negated when MULT operand signs differ.
REQ-020 FIX, divide: LO SHALL get the quotient (negated when DIV signs differ) and HI the remainder (sign of dividend for DIV); then go to IDLE.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (wrap, no trap).
REQ-022 Latency: start accepted in cycle N -> HI/LO updated at the edge ending cycle N+33 and readable from cycle N+34.
REQ-023 MulDiv_Busy SHALL be 1 exactly in CALC and FIX.
REQ-024 Stall_EX SHALL equal MulDiv_Busy AND (MulDiv_Start_EX OR HI_LO_Read_EX), combinationally.
REQ-025 Independent instructions SHALL proceed without stall while Busy.
REQ-026 MulDiv_Start_EX SHALL be sampled only in IDLE; a start asserted while Busy is stalled and then accepted in the first IDLE cycle.
REQ-027 Flush_EX=1 in CALC or FIX SHALL force IDLE next cycle, with HI/LO unchanged and Div_By_Zero unchanged.
REQ-028 Flush_EX=1 together with a start in IDLE SHALL suppress acceptance of that start.
REQ-029 HI_Out/LO_Out SHALL change only at FIX exit or reset.

Reset
REQ-030 Reset_L=0 at a rising edge SHALL set state IDLE, counter 0, HI=LO=0, Div_By_Zero=0 and Busy=0; Stall_EX is then 0.
REQ-031 Reset SHALL take priority over every other input, including mid-CALC; the aborted result is discarded.

Verification
REQ-032 MULT 0xFFFFFFFE x 0x00000003 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; Busy high for 33 cycles.
REQ-033 DIVU 100 / 7 -> LO=14, HI=2; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 DIV x / 0 -> Div_By_Zero=1 next cycle, Busy never asserts, HI/LO keep prior values.
REQ-035 MFHI issued 2 cycles after MULT start -> Stall_EX=1 until Busy drops, then 0; a non-muldiv instruction in the same window -> Stall_EX=0.
REQ-036 Flush_EX at CALC counter 10 -> IDLE next cycle, HI/LO unchanged; Reset_L=0 mid-CALC -> all outputs 0 next cycle.
REQ-037 Back-to-back MULTU starts -> second is stalled and accepted the cycle Busy falls; final result matches the second operation.
